mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Arbiter that shares one single-port synchronous memory between the MIPS instruction-fetch port and the load/store data port. It sits between `datapath_and_controller` and the unified memory. Each requester uses a req/ack handshake. The arbiter sequences every access through a fixed 4-state cycle. The data port has priority, and a starvation counter guarantees instruction-fetch progress.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants allowed while fetch waits (≥1)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  AW  fetch address; stable while `if_req`
- `if_ack`  out  1  one-cycle completion pulse
- `if_rdata`  out  DW  fetched word; valid when `if_ack`=1
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1=store, 0=load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_ack`  out  1  one-cycle completion pulse
- `d_rdata`  out  DW  load data; valid when `d_ack`=1
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en`
- `busy`  out  1  1 when the state is not IDLE

## Operation
- The FSM has four states, IDLE → ISSUE → RESP → DONE → IDLE. There are no other transitions except reset.
- Arbitration happens in IDLE only and is evaluated at the clock edge.
  - Only `d_req`=1: grant data.
  - Only `if_req`=1: grant fetch.
  - Both requests and `starve_cnt` < `STARVE_MAX`: grant data and increment `starve_cnt`.
  - Both requests and `starve_cnt` = `STARVE_MAX`: grant fetch.
  - `starve_cnt` clears to 0 on any fetch grant, and on a data grant made while `if_req`=0.
  - `starve_cnt` is 3 bits wide and saturates at `STARVE_MAX`.
- On a grant, `grant_sel` (internal, 1=data) is registered.
  - `mem_addr` loads from the selected port.
  - `mem_wdata` loads from the selected port; it is 0 for fetch.
  - `mem_we` = `d_we` for data, and 0 for fetch.
- ISSUE: `mem_en`=1. `mem_we`, `mem_addr` and `mem_wdata` are held stable.
- RESP: `mem_en`=0 and `mem_we`=0. `mem_rdata` is captured into the selected port's rdata register. For stores, `d_rdata` is left unchanged.
- DONE: exactly one of `if_ack` / `d_ack` = 1, matching `grant_sel`. The requester must deassert `req`, or present a new request, before the edge that ends DONE.
- The arbiter never samples `req` in ISSUE, RESP or DONE. Changes to `req` or `addr` during those states are ignored.
- A non-granted request stays pending; no request is ever dropped.

## Timing
- Load or fetch latency: request high at edge E0 (state IDLE) → ISSUE in the cycle after E0 → RESP → `ack` and `rdata` valid in the 3rd cycle after E0.
- Peak throughput is one access per 4 cycles. With requests held continuously, IDLE lasts exactly 1 cycle.
- Reset values: all outputs are 0, the state is IDLE, `starve_cnt`=0 and `grant_sel`=0.
- Reset is asynchronous and takes effect mid-access. It clears `mem_en`/`mem_we` immediately and suppresses the pending `ack`. An interrupted store may or may not have been written; a requester must reissue after reset.
- `if_rdata`/`d_rdata` hold their last value between acks.
- Simultaneous arrival of both requests in the same IDLE cycle follows the priority rule above; there is no stalling beyond arbitration.

## Test plan
- Reset: hold `rst`=1 for 2 cycles, then release → all outputs 0, `busy`=0.
- Single fetch:
  - Stimulus: `if_req`=1, `if_addr`=0x0000_0040, memory word 0x2008_0005.
  - Required response: `mem_en`=1 for exactly one cycle with `mem_addr`=0x40 and `mem_we`=0; `if_ack` is a 1-cycle pulse 3 cycles after grant with `if_rdata`=0x2008_0005.
- Store then load:
  - Stimulus: `d_we`=1, `d_addr`=0x54, `d_wdata`=0xDEAD_BEEF, then a load from 0x54.
  - Required response: `mem_we`=1 only during the store's ISSUE cycle; `d_rdata`=0xDEAD_BEEF on the second `d_ack`; `d_rdata` is unchanged on the first `d_ack`.
- Contention and starvation:
  - Stimulus: `if_req` and `d_req` held high continuously, `STARVE_MAX`=4.
  - Required response: the grant sequence is D,D,D,D,F,D,D,D,D,F…; each `ack` is spaced exactly 4 cycles apart.
- Back-to-back: a requester re-asserts a new request in the cycle after `ack` → a new grant occurs, and no duplicate `ack` is issued for the old request.
- Reset mid-access: assert `rst` during RESP of a fetch → `mem_en`=0 immediately, no `if_ack` appears, and after release the FSM is in IDLE with `busy`=0.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous memory between MIPS instruction fetch and the load/store port.
// Every access walks IDLE -> ISSUE -> RESP -> DONE. Data has priority, and a starvation counter guarantees fetch progress.
module mips_mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    state_t     state, state_nx;
    logic [2:0] starve_cnt, starve_nx;
    logic       grant, grant_d;
    logic       grant_sel, we_q;

    always_comb begin
        state_nx  = state;
        starve_nx = starve_cnt;
        grant     = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // Increment only while below SMAX, so the counter saturates at SMAX.
                if (d_req && (!if_req || (starve_cnt < SMAX))) begin
                    grant     = 1'b1;
                    grant_d   = 1'b1;
                    starve_nx = if_req ? (starve_cnt + 3'd1) : '0;
                    state_nx  = ISSUE;
                end else if (if_req) begin
                    grant     = 1'b1;
                    starve_nx = '0;
                    state_nx  = ISSUE;
                end
            end
            ISSUE:   state_nx = RESP;
            RESP:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            grant_sel  <= 1'b0;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            if (grant) begin
                grant_sel <= grant_d;
                we_q      <= grant_d & d_we;
                mem_addr  <= grant_d ? d_addr : if_addr;
                mem_wdata <= grant_d ? d_wdata : '0;
            end
            if (state == RESP) begin
                if (!grant_sel)
                    if_rdata <= mem_rdata;
                else if (!we_q)
                    d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en = (state == ISSUE);
    assign mem_we = (state == ISSUE) && we_q;
    assign if_ack = (state == DONE) && !grant_sel;
    assign d_ack  = (state == DONE) && grant_sel;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized self-checking bench for mips_mem_arbiter.
// It uses a transaction-level timing model, a shadow memory, and directed literal checks.
module tb_mips_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int assertions = 0;
    int failures = 0;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // The environment memory is synchronous, with read data valid the cycle after mem_en.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: t counts cycles since the grant edge (-1 = no access in flight).
    int            t = -1;
    int            cnt = 0;
    bit            m_sel = 0, m_we = 0;
    logic [31:0]   m_addr = '0, m_wdata = '0, m_rd = '0;
    logic [31:0]   e_if_rdata = '0, e_d_rdata = '0;
    logic [31:0]   shadow [256];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = -1; cnt = 0; m_sel = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            e_if_rdata = '0; e_d_rdata = '0;
        end else if (t < 0) begin
            if (d_req && (!if_req || cnt < SMAX)) begin
                m_sel = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                cnt = if_req ? cnt + 1 : 0;
                t = 1;
            end else if (if_req) begin
                m_sel = 0; m_we = 0; m_addr = if_addr; m_wdata = '0;
                cnt = 0;
                t = 1;
            end
        end else begin
            if (t == 1) begin
                m_rd = shadow[m_addr[9:2]];
                if (m_we) shadow[m_addr[9:2]] = m_wdata;
            end
            if (t == 2 && !m_we) begin
                if (m_sel) e_d_rdata = m_rd;
                else e_if_rdata = m_rd;
            end
            t = (t == 3) ? -1 : t + 1;
        end
    end

    always @(negedge clk) begin
        chk("mem_en", 32'(mem_en), 32'(t == 1));
        chk("mem_we", 32'(mem_we), 32'(t == 1 && m_we));
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_ack", 32'(if_ack), 32'(t == 3 && !m_sel));
        chk("d_ack", 32'(d_ack), 32'(t == 3 && m_sel));
        chk("busy", 32'(busy), 32'(t >= 1));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
    end

    function automatic logic [31:0] rnd_addr();
        logic [7:0] w;
        w = 8'($urandom_range(0, 255));
        return {22'd0, w, 2'b00};
    endfunction

    task automatic wait_ack(input bit dport, output int cyc, output int n_en, output int n_we);
        cyc = 0; n_en = 0; n_we = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mem_en) n_en++;
            if (mem_we) n_we++;
        end while (!(dport ? d_ack : if_ack) && cyc < 20);
        if (!(dport ? d_ack : if_ack)) begin
            assertions++; failures++;
            $display("FAIL ack_timeout: got no ack, expected ack within 20 cycles (port %0d)", dport);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if_ack) if_req = 0;
            if (d_ack) d_req = 0;
            if (!if_req && !d_req && !busy) break;
        end
        assertions++;
        if (if_req || d_req || busy) begin
            failures++;
            $display("FAIL drain: got busy=%0d, expected idle", busy);
        end
    endtask

    initial begin
        int cyc, n_en, n_we;
        string seq;
        int ack_cyc [$];
        int nack;

        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            shadow[i] = mem[i];
        end
        mem[8'h10] = 32'h2008_0005;
        shadow[8'h10] = 32'h2008_0005;

        #1 rst = 1;
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_acks", {30'd0, if_ack, d_ack}, 32'd0);

        // Single fetch
        if_addr = 32'h0000_0040; if_req = 1;
        wait_ack(0, cyc, n_en, n_we);
        if_req = 0;
        chk("fetch_latency", 32'(cyc), 32'd3);
        chk("fetch_en_cycles", 32'(n_en), 32'd1);
        chk("fetch_we_cycles", 32'(n_we), 32'd0);
        chk("fetch_rdata", if_rdata, 32'h2008_0005);

        // Store then load
        @(negedge clk);
        d_addr = 32'h54; d_wdata = 32'hDEAD_BEEF; d_we = 1; d_req = 1;
        wait_ack(1, cyc, n_en, n_we);
        chk("store_we_cycles", 32'(n_we), 32'd1);
        chk("store_rdata_unchanged", d_rdata, 32'd0);
        d_we = 0; d_wdata = 32'h0;
        wait_ack(1, cyc, n_en, n_we);
        d_req = 0;
        chk("load_we_cycles", 32'(n_we), 32'd0);
        chk("load_rdata", d_rdata, 32'hDEAD_BEEF);

        // Contention: both held continuously
        @(negedge clk);
        if_addr = 32'h40; d_addr = 32'h54; if_req = 1; d_req = 1;
        seq = "";
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            if (d_ack) begin seq = {seq, "D"}; ack_cyc.push_back(c); end
            if (if_ack) begin seq = {seq, "F"}; ack_cyc.push_back(c); end
        end
        assertions++;
        if (seq.substr(0, 9) != "DDDDFDDDDF") begin
            failures++;
            $display("FAIL grant_seq: got %s, expected DDDDFDDDDF...", seq);
        end
        for (int i = 1; i < ack_cyc.size(); i++)
            chk("ack_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
        drain();

        // Back-to-back: new fetch in the cycle after ack
        if_addr = 32'h40; if_req = 1;
        wait_ack(0, cyc, n_en, n_we);
        if_req = 0;
        @(negedge clk);
        chk("b2b_idle_no_ack", 32'(if_ack), 32'd0);
        if_addr = 32'h54; if_req = 1;
        nack = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (if_ack) begin
                nack++;
                chk("b2b_ack_cycle", 32'(c), 32'd3);
                if_req = 0;
            end
        end
        chk("b2b_ack_count", 32'(nack), 32'd1);
        chk("b2b_rdata", if_rdata, 32'hDEAD_BEEF);
        drain();

        // Reset during RESP of a fetch
        if_addr = 32'h40; if_req = 1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1;
        #1;
        chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_if_rdata", if_rdata, 32'd0);
        if_req = 0;
        @(negedge clk);
        rst = 0;
        nack = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (if_ack) nack++;
        end
        chk("rst_mid_no_ack", 32'(nack), 32'd0);
        chk("rst_mid_idle", 32'(busy), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (if_req ? (if_ack && $urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0)) begin
                if_addr = rnd_addr(); if_req = 1;
            end else if (if_ack) begin
                if_req = 0;
            end
            if (d_req ? (d_ack && $urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0)) begin
                d_addr = rnd_addr(); d_we = 1'($urandom_range(0, 1));
                d_wdata = $urandom; d_req = 1;
            end else if (d_ack) begin
                d_req = 0;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
